// File: rtl/twenty48_pkg.sv
// twenty48_pkg
//   Types and constants shared by the 2048 game input path: the joystick
//   direction encoding, the move-command FSM state encoding, timing defaults
//   and the helper that maps illegal direction codes to center.
package twenty48_pkg;

    typedef logic [2:0] dir_t;

    localparam dir_t DIR_CENTER = 3'd0;
    localparam dir_t DIR_UP     = 3'd1;
    localparam dir_t DIR_DOWN   = 3'd2;
    localparam dir_t DIR_LEFT   = 3'd3;
    localparam dir_t DIR_RIGHT  = 3'd4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PEND     = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    // 5 ms and 0.5 s at 100 MHz
    localparam int STABLE_CYCLES_DEF = 500000;
    localparam int REPEAT_CYCLES_DEF = 50000000;

    // Codes above RIGHT are not produced by a healthy decoder; treat as center.
    function automatic dir_t legalise_dir(input logic [2:0] d);
        return (d > DIR_RIGHT) ? DIR_CENTER : dir_t'(d);
    endfunction

endpackage

// File: rtl/dir_stabilizer.sv
// dir_stabilizer
//   Registers a raw 3-bit code, legalises it and only passes it to stab_dir
//   once it has held unchanged for STABLE_CYCLES consecutive cycles. A code
//   sampled at edge t and held shows on stab_dir at edge t+1+STABLE_CYCLES.
//   Any change before then restarts the count.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-low reset
//   dir       in   raw code
//   stab_dir  out  filtered code
module dir_stabilizer
    import twenty48_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] dir,
    output logic [2:0] stab_dir
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    dir_t             dir_q;
    dir_t             cand;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_q    <= DIR_CENTER;
            cand     <= DIR_CENTER;
            cnt      <= '0;
            stab_dir <= DIR_CENTER;
        end else begin
            dir_q <= legalise_dir(dir);
            if (dir_q != cand) begin
                cand <= dir_q;
                cnt  <= '0;
            end else if (int'(cnt) < STABLE_CYCLES - 1) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                // Counter saturates here; stab_dir keeps following cand.
                stab_dir <= cand;
            end
        end
    end

endmodule

// File: rtl/jstk_move_cmd.sv
// jstk_move_cmd
//   Turns each deliberate joystick deflection into exactly one move command
//   for the 2048 board engine over a valid/ready handshake. The stick must
//   return to center before another move is issued.
//   Optional macro JSTK_AUTO_REPEAT_EN: while the stick stays held on the
//   last accepted direction, a new move is issued every REPEAT_CYCLES.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous, active-low reset
//   dir         in   raw direction code from the joystick decoder
//   move_valid  out  move command pending
//   move_dir    out  direction of the pending move
//   move_ready  in   board engine accepts the move
//   stab_dir    out  filtered direction
//   move_count  out  number of accepted moves, wraps at 256
module jstk_move_cmd
    import twenty48_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] dir,
    output logic       move_valid,
    output logic [2:0] move_dir,
    input  logic       move_ready,
    output logic [2:0] stab_dir,
    output logic [7:0] move_count
);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be >= 1");
    end

    logic [1:0] state;

    dir_stabilizer #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_stab (
        .clk      (clk),
        .rst      (rst),
        .dir      (dir),
        .stab_dir (stab_dir)
    );

`ifdef JSTK_AUTO_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [REP_W-1:0] rep_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            move_valid <= 1'b0;
            move_dir   <= DIR_CENTER;
            move_count <= 8'd0;
`ifdef JSTK_AUTO_REPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stab_dir != DIR_CENTER) begin
                        move_dir   <= stab_dir;
                        move_valid <= 1'b1;
                        state      <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    // The pending move is frozen until accepted, whatever the stick does.
                    if (move_valid && move_ready) begin
                        move_valid <= 1'b0;
                        move_count <= move_count + 8'd1;
                        state      <= ST_WAIT_REL;
`ifdef JSTK_AUTO_REPEAT_EN
                        rep_cnt    <= '0;
`endif
                    end
                end
                ST_WAIT_REL: begin
                    if (stab_dir == DIR_CENTER) begin
                        state <= ST_IDLE;
`ifdef JSTK_AUTO_REPEAT_EN
                        rep_cnt <= '0;
                    end else if (stab_dir == move_dir) begin
                        if (int'(rep_cnt) == REPEAT_CYCLES - 1) begin
                            rep_cnt    <= '0;
                            move_valid <= 1'b1;
                            state      <= ST_PEND;
                        end else begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end
                    end else begin
                        // Moved to another direction without centering.
                        rep_cnt <= '0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_move_cmd.sv
// tb_jstk_move_cmd
//   Directed bench for jstk_move_cmd with STABLE_CYCLES=4, REPEAT_CYCLES=20.
//   A reference model tracks the expected outputs; a compare process checks
//   every cycle, and a few hand-computed literals pin the model.
module tb_jstk_move_cmd;

    localparam int ST = 4;
    localparam int RP = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dir;
    logic       move_valid;
    logic [2:0] move_dir;
    logic       move_ready;
    logic [2:0] stab_dir;
    logic [7:0] move_count;

    int vecs = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    // model state
    int  m_hist [ST+1];
    int  m_stab, m_mdir, m_cnt, m_rep;
    bit  m_pend, m_idle, m_same;

    jstk_move_cmd #(
        .STABLE_CYCLES(ST),
        .REPEAT_CYCLES(RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dir        (dir),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .stab_dir   (stab_dir),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: stab_dir takes a value once the last ST+1 sampled codes agree;
    // a move is issued from center-armed state, held until accepted, and the
    // stick must return to center before re-arming.
    always @(posedge clk) begin
        if (!rst) begin
            m_pend = 1'b0; m_idle = 1'b1; m_mdir = 0; m_cnt = 0; m_rep = 0; m_stab = 0;
            foreach (m_hist[i]) m_hist[i] = 0;
        end else begin
            if (m_pend) begin
                if (move_ready) begin
                    m_pend = 1'b0; m_cnt = (m_cnt + 1) % 256; m_idle = 1'b0; m_rep = 0;
                end
            end else if (m_idle) begin
                if (m_stab != 0) begin
                    m_pend = 1'b1; m_mdir = m_stab;
                end
            end else if (m_stab == 0) begin
                m_idle = 1'b1; m_rep = 0;
            end
`ifdef JSTK_AUTO_REPEAT_EN
            else if (m_stab == m_mdir) begin
                if (m_rep == RP - 1) begin
                    m_rep = 0; m_pend = 1'b1;
                end else begin
                    m_rep++;
                end
            end else begin
                m_rep = 0;
            end
`endif
            m_same = 1'b1;
            for (int i = 1; i <= ST; i++) if (m_hist[i] != m_hist[0]) m_same = 1'b0;
            if (m_same) m_stab = m_hist[0];
            for (int i = ST; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = (dir > 3'd4) ? 0 : int'(dir);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("move_valid", move_valid, m_pend ? 1 : 0);
            if (m_pend) chk("move_dir", move_dir, m_mdir);
            chk("stab_dir", stab_dir, m_stab);
            chk("move_count", move_count, m_cnt);
        end
    end

    task automatic hold(input logic [2:0] d, input int n);
        dir = d;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; dir = 3'd0; move_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_valid", move_valid, 0);
        chk("rst_count", move_count, 0);
        chk("rst_stab", stab_dir, 0);
        rst = 1'b1;
        hold(3'd0, 3);

        // single move: stab_dir after 5 edges, move_valid one edge later
        dir = 3'd1;
        repeat (5) @(negedge clk);
        chk("t1_stab_early", stab_dir, 0);
        @(negedge clk);
        chk("t1_stab", stab_dir, 1);
        chk("t1_valid_early", move_valid, 0);
        @(negedge clk);
        chk("t1_valid", move_valid, 1);
        chk("t1_dir", move_dir, 1);
        repeat (4) @(negedge clk);
        hold(3'd0, 6);               // release while pending: move must stay
        chk("t1_valid_held", move_valid, 1);
        chk("t1_dir_held", move_dir, 1);
        move_ready = 1'b1;
        @(negedge clk);
        move_ready = 1'b0;
        chk("t1_valid_done", move_valid, 0);
        chk("t1_count", move_count, 1);
        hold(3'd0, 4);

        // glitchy stick never stabilises
        for (int i = 0; i < 3; i++) begin
            hold(3'd3, 2);
            hold(3'd0, 2);
        end
        chk("t2_valid", move_valid, 0);
        chk("t2_stab", stab_dir, 0);
        hold(3'd0, 4);

        // no move without passing through center
        hold(3'd4, 7);
        chk("t3_valid", move_valid, 1);
        chk("t3_dir", move_dir, 4);
        move_ready = 1'b1;
        @(negedge clk);
        move_ready = 1'b0;
        chk("t3_count", move_count, 2);
        hold(3'd2, 10);
        chk("t3_nocenter", move_valid, 0);
        hold(3'd0, 6);
        hold(3'd2, 8);
        chk("t3_valid2", move_valid, 1);
        chk("t3_dir2", move_dir, 2);
        move_ready = 1'b1;
        @(negedge clk);
        move_ready = 1'b0;
        chk("t3_count2", move_count, 3);

        // illegal code acts as center
        hold(3'd6, 10);
        chk("t4_valid", move_valid, 0);
        chk("t4_stab", stab_dir, 0);

        // reset during a pending move
        hold(3'd1, 8);
        chk("t5_pending", move_valid, 1);
        rst = 1'b0; dir = 3'd0;
        @(negedge clk);
        rst = 1'b1;
        chk("t5_valid", move_valid, 0);
        chk("t5_count", move_count, 0);
        hold(3'd0, 8);

        // 256 accepted moves wrap the counter
        move_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            hold(3'd1, 8);
            hold(3'd0, 7);
            if (k == 254) chk("wrap_255", move_count, 255);
        end
        chk("wrap_0", move_count, 0);

        // long hold with ready high
        hold(3'd1, 70);
        move_ready = 1'b0;
        hold(3'd0, 8);
`ifdef JSTK_AUTO_REPEAT_EN
        chk("repeat_multi", (move_count > 8'd1) ? 1 : 0, 1);
`else
        chk("no_repeat", move_count, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
